inst_fetcher: RTL

//  Front end of the out-of-order core: fetches 32-bit instructions from mem_ctrl, predicts next PC,
//  and buffers (pc, next_pc, inst) in an instruction queue whose head feeds the issuer.
//  The issuer pops on a clock edge where ready && !is_any_full; a ROB mispredict flush redirects fetch.

---
 rtl/inst_fetcher_pkg.sv | 24 ++
 rtl/inst_fetcher_inst_queue.sv | 60 ++++++
 rtl/inst_fetcher.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher: register/instruction
// types, the opcodes the next-PC predictor recognises, and the queue entry layout.
package inst_fetcher_pkg;

   typedef logic [31:0] reg_t;
   typedef logic [31:0] inst_t;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   typedef struct packed {
      reg_t  pc;
      reg_t  next_pc;
      inst_t inst;
   } iq_entry_t;

   localparam int IQ_ENTRY_W = $bits(iq_entry_t);

   typedef enum logic {
      FETCH_IDLE,
      FETCH_WAIT
   } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_inst_queue.sv
// Circular FIFO holding fetched instructions; the head entry is read
// combinationally and reads as zero while the queue is empty.
module inst_queue #(
   parameter int DEPTH_LOG = 4,
   parameter int WIDTH     = 96
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   input  logic                 flush,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count,
   output logic [WIDTH-1:0]     head_data
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr;
   logic [DEPTH_LOG-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full      = (count == (DEPTH_LOG + 1)'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = empty ? '0 : mem[rd_ptr];

   // Flush simply rewinds the pointers; stale storage is never visible because empty masks the head.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: one outstanding mem_ctrl request, next-PC prediction
// and an instruction queue. Define INST_FETCHER_BHT_EN to enable the 2-bit BHT.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH_LOG = 4,
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          BHT_IDX_W    = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        is_any_full,
   input  logic        reset_from_rob_bus,
   input  logic [31:0] pc_from_rob_bus,
   output logic        valid_to_mem_ctrl,
   output logic [31:0] addr_to_mem_ctrl,
   input  logic        ready_from_mem_ctrl,
   input  logic [31:0] inst_from_mem_ctrl,
   output logic        ready_to_issuer,
   output logic [31:0] pc_to_issuer,
   output logic [31:0] next_pc_to_issuer,
   output logic [31:0] inst_to_issuer,
   input  logic        br_valid_from_rob,
   input  logic [31:0] br_pc_from_rob,
   input  logic        br_taken_from_rob
);

   localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;

   fetch_state_t          state;
   reg_t                  fetch_pc;
   logic [6:0]            opcode;
   reg_t                  j_imm;
   reg_t                  b_imm;
   reg_t                  pred_pc;
   logic                  br_taken_pred;
   logic                  push_en;
   logic                  pop_en;
   logic                  flush_en;
   logic                  iq_full;
   logic                  iq_empty;
   logic [IQ_DEPTH_LOG:0] iq_count;
   iq_entry_t             push_entry;
   logic [IQ_ENTRY_W-1:0] head_data;
   iq_entry_t             head_entry;

`ifdef INST_FETCHER_BHT_EN
   localparam int BHT_SIZE = 1 << BHT_IDX_W;

   logic [1:0]           bht [BHT_SIZE];
   logic [BHT_IDX_W-1:0] lookup_idx;
   logic [BHT_IDX_W-1:0] update_idx;
   logic                 unused_br_pc;

   assign lookup_idx    = fetch_pc[BHT_IDX_W+1:2];
   assign update_idx    = br_pc_from_rob[BHT_IDX_W+1:2];
   assign br_taken_pred = bht[lookup_idx][1];
   assign unused_br_pc  = ^{br_pc_from_rob[31:BHT_IDX_W+2], br_pc_from_rob[1:0]};

   // Saturating 2-bit counters; a same-edge lookup sees the pre-update value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_SIZE; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (rdy && br_valid_from_rob) begin
         if (br_taken_from_rob && (bht[update_idx] != 2'b11)) begin
            bht[update_idx] <= bht[update_idx] + 2'b01;
         end else if (!br_taken_from_rob && (bht[update_idx] != 2'b00)) begin
            bht[update_idx] <= bht[update_idx] - 2'b01;
         end
      end
   end
`else
   logic unused_bht;

   // Backward-taken / forward-not-taken: the B-immediate sign bit is the prediction.
   assign br_taken_pred = inst_from_mem_ctrl[31];
   assign unused_bht    = ^{br_valid_from_rob, br_pc_from_rob, br_taken_from_rob, (BHT_IDX_W > 0)};
`endif

   assign opcode = inst_from_mem_ctrl[6:0];

   always_comb begin
      j_imm   = {{11{inst_from_mem_ctrl[31]}}, inst_from_mem_ctrl[31], inst_from_mem_ctrl[19:12],
                 inst_from_mem_ctrl[20], inst_from_mem_ctrl[30:21], 1'b0};
      b_imm   = {{19{inst_from_mem_ctrl[31]}}, inst_from_mem_ctrl[31], inst_from_mem_ctrl[7],
                 inst_from_mem_ctrl[30:25], inst_from_mem_ctrl[11:8], 1'b0};
      pred_pc = fetch_pc + 32'd4;
      if (opcode == OPCODE_JAL) begin
         pred_pc = fetch_pc + j_imm;
      end else if ((opcode == OPCODE_BRANCH) && br_taken_pred) begin
         pred_pc = fetch_pc + b_imm;
      end
   end

   // A flush beats both push and pop, so a response landing on the flush edge is dropped.
   assign flush_en = rdy && reset_from_rob_bus;
   assign push_en  = rdy && !reset_from_rob_bus && (state == FETCH_WAIT) && ready_from_mem_ctrl && !iq_full;
   assign pop_en   = rdy && !reset_from_rob_bus && !iq_empty && !is_any_full;

   assign push_entry = '{pc: fetch_pc, next_pc: pred_pc, inst: inst_from_mem_ctrl};

   inst_queue #(
      .DEPTH_LOG (IQ_DEPTH_LOG),
      .WIDTH     (IQ_ENTRY_W)
   ) u_inst_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push_en),
      .push_data (push_entry),
      .pop       (pop_en),
      .flush     (flush_en),
      .full      (iq_full),
      .empty     (iq_empty),
      .count     (iq_count),
      .head_data (head_data)
   );

   assign head_entry        = head_data;
   assign ready_to_issuer   = !iq_empty;
   assign pc_to_issuer      = head_entry.pc;
   assign next_pc_to_issuer = head_entry.next_pc;
   assign inst_to_issuer    = head_entry.inst;

   // Request only when a slot is free, so the single outstanding response always has room.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= FETCH_IDLE;
         fetch_pc          <= RESET_PC;
         valid_to_mem_ctrl <= 1'b0;
         addr_to_mem_ctrl  <= '0;
      end else if (rdy) begin
         if (reset_from_rob_bus) begin
            state             <= FETCH_IDLE;
            fetch_pc          <= pc_from_rob_bus;
            valid_to_mem_ctrl <= 1'b0;
         end else begin
            case (state)
               FETCH_IDLE: begin
                  if (iq_count < (IQ_DEPTH_LOG + 1)'(IQ_DEPTH)) begin
                     valid_to_mem_ctrl <= 1'b1;
                     addr_to_mem_ctrl  <= fetch_pc;
                     state             <= FETCH_WAIT;
                  end
               end
               FETCH_WAIT: begin
                  if (ready_from_mem_ctrl) begin
                     fetch_pc          <= pred_pc;
                     valid_to_mem_ctrl <= 1'b0;
                     state             <= FETCH_IDLE;
                  end
               end
               default: state <= FETCH_IDLE;
            endcase
         end
      end
   end

endmodule
